// File: rtl/seg7_pkg.sv
// Shared segment patterns for the seven-segment display blocks.
// Patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_0     = 7'b1000000;
  localparam seg7_t SEG7_1     = 7'b1111001;
  localparam seg7_t SEG7_2     = 7'b0100100;
  localparam seg7_t SEG7_3     = 7'b0110000;
  localparam seg7_t SEG7_4     = 7'b0011001;
  localparam seg7_t SEG7_5     = 7'b0010010;
  localparam seg7_t SEG7_6     = 7'b0000010;
  localparam seg7_t SEG7_7     = 7'b1111000;
  localparam seg7_t SEG7_8     = 7'b0000000;
  localparam seg7_t SEG7_9     = 7'b0010000;
  localparam seg7_t SEG7_A     = 7'b0001000;
  localparam seg7_t SEG7_B     = 7'b0000011;
  localparam seg7_t SEG7_C     = 7'b1000110;
  localparam seg7_t SEG7_D     = 7'b0100001;
  localparam seg7_t SEG7_E     = 7'b0000110;
  localparam seg7_t SEG7_F     = 7'b0001110;
  localparam seg7_t SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_seg
);

  always_comb begin
    o_seg = SEG7_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG7_0;
      4'h1: o_seg = SEG7_1;
      4'h2: o_seg = SEG7_2;
      4'h3: o_seg = SEG7_3;
      4'h4: o_seg = SEG7_4;
      4'h5: o_seg = SEG7_5;
      4'h6: o_seg = SEG7_6;
      4'h7: o_seg = SEG7_7;
      4'h8: o_seg = SEG7_8;
      4'h9: o_seg = SEG7_9;
      4'hA: o_seg = SEG7_A;
      4'hB: o_seg = SEG7_B;
      4'hC: o_seg = SEG7_C;
      4'hD: o_seg = SEG7_D;
      4'hE: o_seg = SEG7_E;
      4'hF: o_seg = SEG7_F;
      default: o_seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for DIGITS common-anode digits with a tear-free shadow.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 100000
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dot,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     an,
  output seg7_t                 seg,
  output logic                  dp_n,
  output logic                  pending
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]         r_prescCnt;
  logic [IW-1:0]         r_idx;
  logic                  r_started;
  logic [4*DIGITS-1:0]   r_bufVal;
  logic [DIGITS-1:0]     r_bufDot;
  logic [4*DIGITS-1:0]   r_shadowVal;
  logic [DIGITS-1:0]     r_shadowDot;

  logic                  w_tick;
  logic                  w_frame;
  logic [3:0]            w_nibble;
  logic                  w_dotSel;
  logic                  w_enSel;
  logic                  w_lzbSel;
  logic [DIGITS-1:0]     w_lzbMask;
  seg7_t                 w_seg;

  assign w_tick  = (r_prescCnt == PRESC_MAX);
  assign w_frame = w_tick && (r_idx == IDX_MAX);

  // Digits stay dark until the first tick after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescCnt <= '0;
      r_idx      <= '0;
      r_started  <= 1'b0;
    end else if (w_tick) begin
      r_prescCnt <= '0;
      r_idx      <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
      r_started  <= 1'b1;
    end else begin
      r_prescCnt <= r_prescCnt + PW'(1);
    end
  end

  // A load landing on the frame boundary bypasses the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bufVal    <= '0;
      r_bufDot    <= '0;
      r_shadowVal <= '0;
      r_shadowDot <= '0;
      pending     <= 1'b0;
    end else begin
      if (load) begin
        r_bufVal <= value;
        r_bufDot <= dot;
      end
      if (w_frame && load) begin
        r_shadowVal <= value;
        r_shadowDot <= dot;
        pending     <= 1'b0;
      end else if (w_frame && pending) begin
        r_shadowVal <= r_bufVal;
        r_shadowDot <= r_bufDot;
        pending     <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  always_comb begin
    logic upperZero;
    w_lzbMask = '0;
    upperZero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upperZero    = upperZero && (r_shadowVal[4*k +: 4] == 4'h0);
      w_lzbMask[k] = upperZero && !r_shadowDot[k];
    end
  end
`else
  assign w_lzbMask = '0;
`endif

  always_comb begin
    w_nibble = '0;
    w_dotSel = 1'b0;
    w_enSel  = 1'b0;
    w_lzbSel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nibble = r_shadowVal[4*k +: 4];
        w_dotSel = r_shadowDot[k];
        w_enSel  = digit_en[k];
        w_lzbSel = w_lzbMask[k];
      end
    end
  end

  hex_to_seg7 u_hexToSeg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an   <= '1;
      seg  <= SEG7_BLANK;
      dp_n <= 1'b1;
    end else if (!r_started || !w_enSel || w_lzbSel) begin
      an   <= '1;
      seg  <= SEG7_BLANK;
      dp_n <= 1'b1;
    end else begin
      an   <= ~(DIGITS'(1) << r_idx);
      seg  <= w_seg;
      dp_n <= ~w_dotSel;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with DIGITS=4, PRESCALE=4.
// Expected output frames are queued when loads are driven and checked cycle by cycle.
module tb_seg7_scan_driver;

  typedef struct {
    int          cyc;
    logic [11:0] exp;
  } sbItem_t;

`ifdef SEG7_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dot = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        pending;

  int      compared = 0;
  int      mismatched = 0;
  int      cyc = 0;
  sbItem_t sb[$];

  seg7_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .dot      (dot),
    .digit_en (digit_en),
    .an       (an),
    .seg      (seg),
    .dp_n     (dp_n),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] expSeg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d);
    load  = ld;
    value = v;
    dot   = d;
  endtask

  // Four cycles of one digit slot starting at cycle c0.
  task automatic pushSlot(input int c0, input int k, input logic [15:0] v,
                          input logic [3:0] d, input logic [3:0] en);
    sbItem_t it;
    for (int c = 0; c < 4; c++) begin
      it.cyc = c0 + c;
      if (en[k]) begin
        logic [3:0] anExp;
        anExp  = ~(4'b0001 << k);
        it.exp = {anExp, expSeg(v[4*k +: 4]), ~d[k]};
      end else begin
        it.exp = {4'hF, 7'h7F, 1'b1};
      end
      sb.push_back(it);
    end
  endtask

  task automatic pushFrame(input int f, input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
    for (int k = 0; k < 4; k++) pushSlot(16*f + 4*k + 1, k, v, d, en);
  endtask

  task automatic drainScoreboard();
    sbItem_t it;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      checkOutput($sformatf("scan_cyc%0d", it.cyc), {20'd0, an, seg, dp_n}, {20'd0, it.exp});
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    checkOutput("rstInit_an", {28'd0, an}, 32'hF);
    checkOutput("rstInit_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rstInit_dp", {31'd0, dp_n}, 32'd1);
    checkOutput("rstInit_pend", {31'd0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int e = 1; e <= 150; e++) begin
      @(negedge clk);
      cyc = e;
      drainScoreboard();
      case (e)
        2: begin
          applyStimulus(1'b1, 16'h12AF, 4'b0000);
          pushFrame(1, 16'h12AF, 4'b0000, 4'hF);
          pushFrame(2, 16'h12AF, 4'b0000, 4'hF);
        end
        3:  begin applyStimulus(1'b0, 16'h0, 4'h0); checkOutput("pendLoad", {31'd0, pending}, 32'd1); end
        16: checkOutput("pendBoundary", {31'd0, pending}, 32'd0);
        39: begin applyStimulus(1'b1, 16'h1111, 4'b0000); pushFrame(3, 16'h1111, 4'b0000, 4'hF); end
        40: begin applyStimulus(1'b0, 16'h0, 4'h0); checkOutput("pendMid", {31'd0, pending}, 32'd1); end
        47: checkOutput("pendHold", {31'd0, pending}, 32'd1);
        48: checkOutput("pendClear", {31'd0, pending}, 32'd0);
        63: begin
          applyStimulus(1'b1, 16'h0005, 4'b0000);
          pushFrame(4, 16'h0005, 4'b0000, LZB ? 4'b0001 : 4'b1111);
        end
        64: begin applyStimulus(1'b0, 16'h0, 4'h0); checkOutput("pendSimul", {31'd0, pending}, 32'd0); end
        69: applyStimulus(1'b1, 16'h0001, 4'b0000);
        70: begin applyStimulus(1'b0, 16'h0, 4'h0); checkOutput("pendDouble", {31'd0, pending}, 32'd1); end
        74: begin
          applyStimulus(1'b1, 16'h0002, 4'b0000);
          pushFrame(5, 16'h0002, 4'b0000, LZB ? 4'b0001 : 4'b1111);
        end
        75: applyStimulus(1'b0, 16'h0, 4'h0);
        80: checkOutput("pendDoubleClr", {31'd0, pending}, 32'd0);
        89: begin
          applyStimulus(1'b1, 16'h4321, 4'b0001);
          pushFrame(6, 16'h4321, 4'b0001, 4'b0101);
        end
        90: applyStimulus(1'b0, 16'h0, 4'h0);
        96: digit_en = 4'b0101;
        99: begin
          applyStimulus(1'b1, 16'h0030, 4'b0000);
          pushFrame(7, 16'h0030, 4'b0000, LZB ? 4'b0011 : 4'b1111);
        end
        100: applyStimulus(1'b0, 16'h0, 4'h0);
        112: digit_en = 4'hF;
        119: begin
          applyStimulus(1'b1, 16'h0000, 4'b0000);
          pushFrame(8, 16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111);
        end
        120: applyStimulus(1'b0, 16'h0, 4'h0);
        140: applyStimulus(1'b1, 16'h00FF, 4'b0000);
        141: begin applyStimulus(1'b0, 16'h0, 4'h0); checkOutput("pendPreRst", {31'd0, pending}, 32'd1); end
        default: ;
      endcase
    end

    // Asynchronous reset in the middle of the low clock phase.
    #2 rst = 1'b1;
    #1;
    checkOutput("rstMid_an", {28'd0, an}, 32'hF);
    checkOutput("rstMid_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rstMid_dp", {31'd0, dp_n}, 32'd1);
    checkOutput("rstMid_pend", {31'd0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    pushSlot(1, 0, 16'h0, 4'b0000, 4'b0000);
    for (int k = 1; k < 4; k++) pushSlot(4*k + 1, k, 16'h0, 4'b0000, LZB ? 4'b0001 : 4'b1111);
    pushFrame(1, 16'h0000, 4'b0000, LZB ? 4'b0001 : 4'b1111);

    for (int e = 1; e <= 32; e++) begin
      @(negedge clk);
      cyc = e;
      drainScoreboard();
    end
    checkOutput("sbDrained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
